dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15: extra cycles between request acceptance and response.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req_valid, input, 1 bit: core presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: write data.
REQ-010 SHALL have port req_wstrb, input, 4 bits: byte-lane write enables, bit n -> wdata[8n+7:8n].
REQ-011 SHALL have port resp_valid, output, 1 bit: response available.
REQ-012 SHALL have port resp_ready, input, 1 bit: core accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32 bits: read data; 0 for writes and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL assert req_ready only in IDLE, combinationally from state.
REQ-017 SHALL accept a request when req_valid & req_ready at a rising edge, capturing we, addr, wdata, wstrb.
REQ-018 SHALL go IDLE -> RESP on acceptance when WAIT_CYCLES = 0, otherwise IDLE -> WAIT with wait counter loaded to WAIT_CYCLES.
REQ-019 SHALL decrement the wait counter each cycle in WAIT and go WAIT -> RESP on the edge where the counter equals 1.
REQ-020 SHALL give accept-to-resp_valid latency of exactly WAIT_CYCLES+1 cycles.
REQ-021 SHALL flag an error when captured addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-022 SHALL, for an error, leave memory unchanged and drive resp_rdata = 0, resp_err = 1.
REQ-023 SHALL perform a write on the edge entering RESP, updating only lanes with wstrb bit set; wstrb = 0 is a legal no-op write.
REQ-024 SHALL load resp_rdata from memory word addr[31:2] on the edge entering RESP for reads.
REQ-025 SHALL return pre-write contents for a read issued after a write to the same word only if the write has not yet reached RESP; this cannot occur with one outstanding request, so reads SHALL always observe all prior writes.
REQ-026 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1.
REQ-027 SHALL go RESP -> IDLE on the edge with resp_ready = 1, clearing resp_valid, resp_rdata and resp_err.
REQ-028 SHALL ignore req_valid outside IDLE: no capture, no queuing, one outstanding request maximum.
REQ-029 SHALL allow a back-to-back request the cycle after the RESP -> IDLE transition.
REQ-030 SHALL keep resp_err and resp_rdata at 0 whenever resp_valid = 0.

Reset
REQ-031 SHALL, while reset = 0, force state IDLE, wait counter 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, independent of clk.
REQ-032 SHALL, on reset mid-operation in WAIT or RESP, abandon the transaction, with no write performed if RESP was not yet reached.
REQ-033 SHALL not reset memory contents; contents after power-up are undefined.

Verification
REQ-034 Bench SHALL check: write 0xDEADBEEF to 0x10 with wstrb 0xF, then read 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid exactly WAIT_CYCLES+1 cycles after each accept.
REQ-035 Bench SHALL check: after REQ-034, write 0x000000AA to 0x10 with wstrb 0x1, then read -> 0xDEADBEAA.
REQ-036 Bench SHALL check: read 0x13 -> err 1, rdata 0; write 0x400 (DEPTH 256) then read 0x000 -> word 0 unchanged.
REQ-037 Bench SHALL check: hold resp_ready = 0 for 5 cycles -> resp_valid and rdata held stable, req_ready 0, a req_valid pulse during this time ignored.
REQ-038 Bench SHALL check: assert reset low in WAIT of a write to 0x20 -> outputs at reset values immediately; subsequent read of 0x20 returns its prior value.
REQ-039 Bench SHALL check: with WAIT_CYCLES = 0 and resp_ready tied 1, back-to-back reads -> one response every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding request/response slave with a
// configurable wait-state delay, byte-lane writes and alignment/range errors.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        mem_we;
    logic        eff_we;
    logic        eff_err;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [3:0]  eff_wstrb;
    logic [AW-1:0] eff_idx;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // With zero wait states RESP is entered on the accepting edge itself, so
    // the live request inputs stand in for the not-yet-captured copy.
    assign eff_we    = (state == IDLE) ? req_we    : cap_we;
    assign eff_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign eff_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign eff_wstrb = (state == IDLE) ? req_wstrb : cap_wstrb;
    assign eff_idx   = eff_addr[AW+1:2];
    assign eff_err   = (eff_addr[1:0] != 2'b00) ||
                       ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));

    // Memory update only on a legal write reaching RESP, never under reset.
    assign mem_we = enter_resp && eff_we && !eff_err && reset;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and RESP-entry strobe.
    always_comb begin
        next_state = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        enter_resp = (next_state == RESP) && (state != RESP);
    end

    // Request capture, wait counter and registered response fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_wstrb <= req_wstrb;
            end

            if (state == IDLE) begin
                if (accept && (WAIT_CYCLES != 0)) begin
                    wait_cnt <= WAIT_LOAD;
                end
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (enter_resp) begin
                resp_err   <= eff_err;
                resp_rdata <= (eff_err || eff_we) ? '0 : mem[eff_idx];
            end else if ((state == RESP) && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

    // Byte-lane memory write; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (eff_wstrb[lane]) begin
                    mem[eff_idx][8*lane +: 8] <= eff_wdata[8*lane +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level model plus directed vectors.
// Instance 0 runs with three wait states, instance 1 with none.
module tb_dmem_responder;

    localparam int W0    = 3;
    localparam int W1    = 0;
    localparam int DEPTH = 256;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    logic        rv     [2];
    logic        rr     [2];
    logic        rwe    [2];
    logic [31:0] raddr  [2];
    logic [31:0] rwdata [2];
    logic [3:0]  rwstrb [2];
    logic        sv     [2];
    logic        sr     [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(rv[0]), .req_ready(rr[0]), .req_we(rwe[0]),
        .req_addr(raddr[0]), .req_wdata(rwdata[0]), .req_wstrb(rwstrb[0]),
        .resp_valid(sv[0]), .resp_ready(sr[0]), .resp_rdata(rdata[0]), .resp_err(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(rv[1]), .req_ready(rr[1]), .req_we(rwe[1]),
        .req_addr(raddr[1]), .req_wdata(rwdata[1]), .req_wstrb(rwstrb[1]),
        .resp_valid(sv[1]), .resp_ready(sr[1]), .resp_rdata(rdata[1]), .resp_err(err[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wc(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    // ---------------- transaction-level reference model ----------------
    bit          m_busy  [2];
    bit          m_shown [2];
    bit          m_we    [2];
    bit          m_err   [2];
    bit          m_known [2];
    bit [31:0]   m_addr  [2];
    bit [31:0]   m_wdata [2];
    bit [31:0]   m_rdata [2];
    bit [3:0]    m_wstrb [2];
    int          m_show_at [2];
    bit [31:0]   mm [2][DEPTH];
    bit          mk [2][DEPTH];
    int          cyc = 0;

    task automatic produce(input int i);
        int unsigned word;
        bit [31:0]   cur;
        word       = m_addr[i] / 4;
        m_err[i]   = ((m_addr[i] % 4) != 0) || (word >= DEPTH);
        m_rdata[i] = 32'h0;
        m_known[i] = 1'b1;
        if (!m_err[i]) begin
            if (m_we[i]) begin
                cur = mm[i][word];
                for (int b = 0; b < 4; b++) begin
                    if (m_wstrb[i][b]) cur[8*b +: 8] = m_wdata[i][8*b +: 8];
                end
                mm[i][word] = cur;
                if (m_wstrb[i] == 4'hF) mk[i][word] = 1'b1;
            end else begin
                m_rdata[i] = mm[i][word];
                m_known[i] = mk[i][word];
            end
        end
        m_shown[i] = 1'b1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i]  = 1'b0;
                m_shown[i] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                bit was_busy;
                was_busy = m_busy[i];
                if (was_busy && m_shown[i] && sr[i]) begin
                    m_busy[i]  = 1'b0;
                    m_shown[i] = 1'b0;
                end else if (!was_busy && rv[i]) begin
                    m_busy[i]    = 1'b1;
                    m_we[i]      = rwe[i];
                    m_addr[i]    = raddr[i];
                    m_wdata[i]   = rwdata[i];
                    m_wstrb[i]   = rwstrb[i];
                    m_show_at[i] = cyc + wc(i);
                end
                if (m_busy[i] && !m_shown[i] && (cyc == m_show_at[i])) produce(i);
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en && reset) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d.req_ready", i), 32'(rr[i]), 32'(!m_busy[i]));
                check($sformatf("d%0d.resp_valid", i), 32'(sv[i]), 32'(m_shown[i]));
                check($sformatf("d%0d.resp_err", i), 32'(err[i]), 32'(m_shown[i] && m_err[i]));
                if (!m_shown[i] || m_known[i])
                    check($sformatf("d%0d.resp_rdata", i), rdata[i], m_shown[i] ? m_rdata[i] : 32'h0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input int i, input bit we, input bit [31:0] addr,
                          input bit [31:0] wdata, input bit [3:0] strb,
                          output int lat, output bit [31:0] data, output bit e);
        int t;
        lat  = -1;
        data = 32'h0;
        e    = 1'b0;
        @(negedge clk);
        t = 0;
        while (!rr[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rr[i]) check("req_ready_timeout", 32'(rr[i]), 32'd1);
        rv[i]     = 1'b1;
        rwe[i]    = we;
        raddr[i]  = addr;
        rwdata[i] = wdata;
        rwstrb[i] = strb;
        @(negedge clk);
        rv[i] = 1'b0;
        t = 0;
        while (!sv[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!sv[i]) check("resp_valid_timeout", 32'(sv[i]), 32'd1);
        lat  = t + 1;
        data = rdata[i];
        e    = err[i];
        sr[i] = 1'b1;
        @(negedge clk);
        sr[i] = 1'b0;
    endtask

    initial begin
        int        lat;
        bit [31:0] d;
        bit        e;
        int        t;
        int        highs;
        bit        smp [12];

        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0;
            rwdata[i] = '0; rwstrb[i] = '0; sr[i] = 1'b0;
        end

        #1;
        check("reset.req_ready", 32'(rr[0]), 32'd1);
        check("reset.resp_valid", 32'(sv[0]), 32'd0);
        check("reset.resp_rdata", rdata[0], 32'h0);
        check("reset.resp_err", 32'(err[0]), 32'd0);
        #21 reset = 1'b1;
        chk_en = 1'b1;

        // Known contents for words used later.
        do_req(0, 1, 32'h0000_0000, 32'h1122_3344, 4'hF, lat, d, e);
        do_req(0, 1, 32'h0000_0020, 32'h0102_0304, 4'hF, lat, d, e);

        // Full write then read of 0x10, with latency.
        do_req(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat, d, e);
        check("wr10.lat", 32'(lat), 32'd4);
        check("wr10.err", 32'(e), 32'd0);
        check("wr10.rdata", d, 32'h0);
        do_req(0, 0, 32'h0000_0010, 32'h0, 4'h0, lat, d, e);
        check("rd10.lat", 32'(lat), 32'd4);
        check("rd10.err", 32'(e), 32'd0);
        check("rd10.rdata", d, 32'hDEAD_BEEF);

        // Single-lane write.
        do_req(0, 1, 32'h0000_0010, 32'h0000_00AA, 4'h1, lat, d, e);
        do_req(0, 0, 32'h0000_0010, 32'h0, 4'h0, lat, d, e);
        check("rd10_lane0.rdata", d, 32'hDEAD_BEAA);

        // wstrb = 0 is a no-op.
        do_req(0, 1, 32'h0000_0010, 32'h1234_5678, 4'h0, lat, d, e);
        check("wr_nostrb.err", 32'(e), 32'd0);
        do_req(0, 0, 32'h0000_0010, 32'h0, 4'h0, lat, d, e);
        check("rd_nostrb.rdata", d, 32'hDEAD_BEAA);

        // Errors: misaligned read, out-of-range write.
        do_req(0, 0, 32'h0000_0013, 32'h0, 4'h0, lat, d, e);
        check("rd13.err", 32'(e), 32'd1);
        check("rd13.rdata", d, 32'h0);
        do_req(0, 1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, lat, d, e);
        check("wr400.err", 32'(e), 32'd1);
        check("wr400.lat", 32'(lat), 32'd4);
        do_req(0, 0, 32'h0000_0000, 32'h0, 4'h0, lat, d, e);
        check("rd0.rdata", d, 32'h1122_3344);
        check("rd0.err", 32'(e), 32'd0);

        // Last legal word, middle-lane merge.
        do_req(0, 1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, lat, d, e);
        check("wr3fc.err", 32'(e), 32'd0);
        do_req(0, 1, 32'h0000_03FC, 32'h00FF_FF00, 4'h6, lat, d, e);
        do_req(0, 0, 32'h0000_03FC, 32'h0, 4'h0, lat, d, e);
        check("rd3fc.rdata", d, 32'hA5FF_FFA5);

        // Stalled response with an ignored request pulse.
        @(negedge clk);
        rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h10; rwstrb[0] = 4'h0;
        @(negedge clk);
        rv[0] = 1'b0;
        t = 0;
        while (!sv[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int c = 0; c < 5; c++) begin
            check("stall.resp_valid", 32'(sv[0]), 32'd1);
            check("stall.resp_rdata", rdata[0], 32'hDEAD_BEAA);
            check("stall.req_ready", 32'(rr[0]), 32'd0);
            if (c == 1) begin
                rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 32'h10;
                rwdata[0] = 32'h0; rwstrb[0] = 4'hF;
            end
            if (c == 2) rv[0] = 1'b0;
            @(negedge clk);
        end
        sr[0] = 1'b1;
        @(negedge clk);
        sr[0] = 1'b0;
        check("stall_rel.resp_valid", 32'(sv[0]), 32'd0);
        check("stall_rel.req_ready", 32'(rr[0]), 32'd1);
        do_req(0, 0, 32'h0000_0010, 32'h0, 4'h0, lat, d, e);
        check("stall_after.rdata", d, 32'hDEAD_BEAA);

        // Reset while a read response is held.
        @(negedge clk);
        rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h10;
        @(negedge clk);
        rv[0] = 1'b0;
        t = 0;
        while (!sv[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        #2 reset = 1'b0;
        #1;
        check("rst_resp.resp_valid", 32'(sv[0]), 32'd0);
        check("rst_resp.resp_rdata", rdata[0], 32'h0);
        check("rst_resp.req_ready", 32'(rr[0]), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;

        // Reset during the wait phase of a write to 0x20.
        @(negedge clk);
        rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 32'h20;
        rwdata[0] = 32'h5555_5555; rwstrb[0] = 4'hF;
        @(negedge clk);
        rv[0] = 1'b0;
        @(negedge clk);
        check("rst_wait.req_ready_before", 32'(rr[0]), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_wait.req_ready", 32'(rr[0]), 32'd1);
        check("rst_wait.resp_valid", 32'(sv[0]), 32'd0);
        check("rst_wait.resp_rdata", rdata[0], 32'h0);
        check("rst_wait.resp_err", 32'(err[0]), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        do_req(0, 0, 32'h0000_0020, 32'h0, 4'h0, lat, d, e);
        check("rd20_after_rst.rdata", d, 32'h0102_0304);
        check("rd20_after_rst.lat", 32'(lat), 32'd4);

        // Zero wait states: latency 1 and back-to-back throughput.
        do_req(1, 1, 32'h0000_0008, 32'h0BAD_F00D, 4'hF, lat, d, e);
        check("d1.wr8.lat", 32'(lat), 32'd1);
        do_req(1, 0, 32'h0000_0008, 32'h0, 4'h0, lat, d, e);
        check("d1.rd8.lat", 32'(lat), 32'd1);
        check("d1.rd8.rdata", d, 32'h0BAD_F00D);
        @(negedge clk);
        sr[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 32'h8; rv[1] = 1'b1;
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            smp[c] = sv[1];
            if (sv[1]) highs++;
        end
        rv[1] = 1'b0;
        @(negedge clk);
        sr[1] = 1'b0;
        check("b2b.responses", 32'(highs), 32'd6);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("b2b.sample%0d", c), 32'(smp[c]), 32'((c % 2) == 0));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
